// File: rtl/game_controller.sv
// Control FSM for the FPGA sequence game: conditions the enter pushbutton and sequences the datapath.
// Optional AUTO_RESTART_EN: leave RESULT automatically after P_RESULT_HOLD cycles.
module game_controller #(
   parameter int P_STATE_W     = 3,
   parameter int P_RESULT_HOLD = 250000000,
   parameter int P_HOLD_W      = 28
) (
   input  logic                 clock_50,
   input  logic                 reset_n,
   input  logic                 enter_n,
   input  logic                 end_fpga,
   input  logic                 end_user,
   input  logic                 end_time,
   input  logic                 win,
   input  logic                 match,
   output logic                 r1,
   output logic                 r2,
   output logic                 e1,
   output logic                 e2,
   output logic                 e3,
   output logic                 e4,
   output logic                 sel,
   output logic                 result_win,
   output logic [P_STATE_W-1:0] state
);

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_SETUP      = 3'd1,
      S_PLAY_FPGA  = 3'd2,
      S_PLAY_USER  = 3'd3,
      S_CHECK      = 3'd4,
      S_NEXT_ROUND = 3'd5,
      S_RESULT     = 3'd6,
      S_ILLEGAL    = 3'd7
   } state_t;

   state_t r_state;
   state_t w_next;

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_enter_p;
   logic r_result_win;
   logic w_hold_done;

   // Sync flops idle high so the button reads released straight out of reset.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_sync3   <= 1'b1;
         r_enter_p <= 1'b0;
      end else begin
         r_sync1   <= enter_n;
         r_sync2   <= r_sync1;
         r_sync3   <= r_sync2;
         r_enter_p <= r_sync3 & ~r_sync2;
      end
   end

`ifdef AUTO_RESTART_EN
   logic [P_HOLD_W-1:0] r_hold_cnt;

   // Counts only while staying in RESULT, so it reads 0 on every RESULT entry.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_cnt <= '0;
      end else if (r_state == S_RESULT && w_next == S_RESULT) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
         r_hold_cnt <= '0;
      end
   end

   assign w_hold_done = (r_hold_cnt == P_HOLD_W'(P_RESULT_HOLD - 1));
`else
   logic w_unused_hold;

   assign w_unused_hold = ^(P_HOLD_W'(P_RESULT_HOLD));
   assign w_hold_done   = 1'b0;
`endif

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:      w_next = S_SETUP;
         S_SETUP:     if (r_enter_p) w_next = S_PLAY_FPGA;
         S_PLAY_FPGA: if (end_fpga) w_next = S_PLAY_USER;
         S_PLAY_USER: begin
            // A timeout wins over a completed entry in the same cycle.
            if (end_time) begin
               w_next = S_RESULT;
            end else if (end_user) begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (match && !win) begin
               w_next = S_NEXT_ROUND;
            end else begin
               w_next = S_RESULT;
            end
         end
         S_NEXT_ROUND: w_next = S_PLAY_FPGA;
         S_RESULT:     if (r_enter_p || w_hold_done) w_next = S_INIT;
         default:      w_next = S_INIT;
      endcase
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_result_win <= 1'b0;
      end else if (r_state == S_INIT) begin
         r_result_win <= 1'b0;
      end else if (r_state == S_CHECK) begin
         r_result_win <= match & win;
      end
   end

   // Strobes are pure decodes of the state, except e4 which follows the button pulse.
   always_comb begin
      r1  = 1'b0;
      r2  = 1'b0;
      e1  = 1'b0;
      e2  = 1'b0;
      e3  = 1'b0;
      e4  = 1'b0;
      sel = 1'b0;
      case (r_state)
         S_INIT: begin
            r1 = 1'b1;
            r2 = 1'b1;
         end
         S_SETUP: begin
            e1 = 1'b1;
            r2 = 1'b1;
         end
         S_PLAY_FPGA: begin
            e3 = 1'b1;
            r2 = 1'b1;
         end
         S_PLAY_USER: begin
            e2 = 1'b1;
            e4 = r_enter_p;
         end
         S_CHECK: begin
         end
         S_NEXT_ROUND: begin
            e1 = 1'b1;
            r2 = 1'b1;
         end
         S_RESULT: begin
            sel = 1'b1;
         end
         default: begin
            r1 = 1'b1;
            r2 = 1'b1;
         end
      endcase
   end

   assign result_win = r_result_win;
   assign state      = P_STATE_W'(r_state);

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: the driver queues expected output snapshots, the monitor
// pops one on every state change or e4 pulse and compares.
module tb_game_controller;

   logic       clock_50 = 1'b0;
   logic       reset_n  = 1'b1;
   logic       enter_n  = 1'b1;
   logic       end_fpga = 1'b0;
   logic       end_user = 1'b0;
   logic       end_time = 1'b0;
   logic       win      = 1'b0;
   logic       match    = 1'b0;
   logic       r1, r2, e1, e2, e3, e4, sel, result_win;
   logic [2:0] state;

   int tests_run = 0;
   int tests_failed = 0;
   int e4_cnt = 0;

   logic [10:0] exp_q[$];
   logic [2:0]  last_state = 3'd0;

   game_controller #(
      .P_STATE_W    (3),
      .P_RESULT_HOLD(20),
      .P_HOLD_W     (28)
   ) dut (
      .clock_50  (clock_50),
      .reset_n   (reset_n),
      .enter_n   (enter_n),
      .end_fpga  (end_fpga),
      .end_user  (end_user),
      .end_time  (end_time),
      .win       (win),
      .match     (match),
      .r1        (r1),
      .r2        (r2),
      .e1        (e1),
      .e2        (e2),
      .e3        (e3),
      .e4        (e4),
      .sel       (sel),
      .result_win(result_win),
      .state     (state)
   );

   // clock / watchdog
   always #5 clock_50 = ~clock_50;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Expected snapshot {state, r1, r2, e1, e2, e3, e4, sel, result_win} from the state table.
   function automatic logic [10:0] f_exp(input logic [2:0] st, input logic e4x, input logic rw);
      logic [6:0] o;
      case (st)
         3'd0:    o = 7'b1100000;
         3'd1:    o = 7'b0110000;
         3'd2:    o = 7'b0100100;
         3'd3:    o = {4'b0001, 1'b0, e4x, 1'b0};
         3'd4:    o = 7'b0000000;
         3'd5:    o = 7'b0110000;
         3'd6:    o = 7'b0000001;
         default: o = 7'b1100000;
      endcase
      return {st, o, rw};
   endfunction

   function automatic logic [10:0] f_cur();
      return {state, r1, r2, e1, e2, e3, e4, sel, result_win};
   endfunction

   // monitor / scoreboard
   always @(negedge clock_50) begin
      logic [10:0] cur;
      logic [10:0] exp_v;
      cur = f_cur();
      if (e4) e4_cnt++;
      if (state != last_state || e4) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected: got %h, required no event", cur);
         end else begin
            exp_v = exp_q.pop_front();
            if (cur !== exp_v) begin
               tests_failed++;
               $display("FAIL sb_event: got %h, required %h", cur, exp_v);
            end
         end
      end
      last_state = state;
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(posedge clock_50);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests_run++;
      if (act !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (state == st) return;
         cyc(1);
      end
      tests_run++;
      tests_failed++;
      $display("FAIL wait_state: got state %0d, required %0d within %0d cycles", state, st, limit);
   endtask

   task automatic press();
      enter_n = 1'b0;
      cyc(4);
      enter_n = 1'b1;
      cyc(4);
   endtask

   task automatic pulse_end_fpga();
      exp_q.push_back(f_exp(3'd3, 1'b0, 1'b0));
      end_fpga = 1'b1;
      cyc(1);
      end_fpga = 1'b0;
   endtask

   initial begin
      int n;
      cyc(1);
      // 1: reset and start-up
      #1 reset_n = 1'b0;
      cyc(3);
      check("reset_outputs", f_cur(), f_exp(3'd0, 1'b0, 1'b0));
      exp_q.push_back(f_exp(3'd1, 1'b0, 1'b0));
      reset_n = 1'b1;
      cyc(1);
      check("startup_setup", {state, e1}, {3'd1, 1'b1});

      // 2: full winning round
      exp_q.push_back(f_exp(3'd2, 1'b0, 1'b0));
      press();
      wait_state(3'd2, 20);
      cyc(10);
      pulse_end_fpga();
      check("play_user_entry", state, 3'd3);
      e4_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(f_exp(3'd3, 1'b1, 1'b0));
         press();
      end
      check("e4_count", e4_cnt, 4);
      match = 1'b1;
      win   = 1'b1;
      exp_q.push_back(f_exp(3'd4, 1'b0, 1'b0));
      exp_q.push_back(f_exp(3'd6, 1'b0, 1'b1));
      end_user = 1'b1;
      cyc(1);
      end_user = 1'b0;
      check("check_state", state, 3'd4);
      cyc(1);
      check("win_result", {state, sel, result_win}, {3'd6, 1'b1, 1'b1});

      // 3: next round
      exp_q.push_back(f_exp(3'd0, 1'b0, 1'b1));
      exp_q.push_back(f_exp(3'd1, 1'b0, 1'b0));
      press();
      wait_state(3'd1, 20);
      exp_q.push_back(f_exp(3'd2, 1'b0, 1'b0));
      press();
      wait_state(3'd2, 20);
      pulse_end_fpga();
      win = 1'b0;
      exp_q.push_back(f_exp(3'd4, 1'b0, 1'b0));
      exp_q.push_back(f_exp(3'd5, 1'b0, 1'b0));
      exp_q.push_back(f_exp(3'd2, 1'b0, 1'b0));
      end_user = 1'b1;
      cyc(1);
      end_user = 1'b0;
      cyc(1);
      check("next_round", {state, e1, r2}, {3'd5, 1'b1, 1'b1});
      cyc(1);
      check("after_next_round", state, 3'd2);

      // 4: timeout priority over end_user
      pulse_end_fpga();
      match = 1'b1;
      win   = 1'b1;
      exp_q.push_back(f_exp(3'd6, 1'b0, 1'b0));
      end_time = 1'b1;
      end_user = 1'b1;
      cyc(1);
      end_time = 1'b0;
      end_user = 1'b0;
      check("timeout_result", {state, result_win}, {3'd6, 1'b0});

      // 5: long press gives one pulse, then async reset mid-game
      exp_q.push_back(f_exp(3'd0, 1'b0, 1'b0));
      exp_q.push_back(f_exp(3'd1, 1'b0, 1'b0));
      press();
      wait_state(3'd1, 20);
      exp_q.push_back(f_exp(3'd2, 1'b0, 1'b0));
      enter_n = 1'b0;
      cyc(10);
      pulse_end_fpga();
      cyc(89);
      enter_n = 1'b1;
      cyc(5);
      check("long_press_state", state, 3'd3);
      exp_q.push_back(f_exp(3'd0, 1'b0, 1'b0));
      #2 reset_n = 1'b0;
      #1;
      check("async_reset", {state, e2, r1, r2}, {3'd0, 1'b0, 1'b1, 1'b1});
      cyc(3);
      exp_q.push_back(f_exp(3'd1, 1'b0, 1'b0));
      reset_n = 1'b1;
      wait_state(3'd1, 5);

      // 6: auto-restart (or lack of it)
      exp_q.push_back(f_exp(3'd2, 1'b0, 1'b0));
      press();
      wait_state(3'd2, 20);
      pulse_end_fpga();
      exp_q.push_back(f_exp(3'd6, 1'b0, 1'b0));
      end_time = 1'b1;
      cyc(1);
      end_time = 1'b0;
      check("result_entry", state, 3'd6);
`ifdef AUTO_RESTART_EN
      exp_q.push_back(f_exp(3'd0, 1'b0, 1'b0));
      exp_q.push_back(f_exp(3'd1, 1'b0, 1'b0));
      n = 0;
      while (state != 3'd0 && n < 100) begin
         cyc(1);
         n++;
      end
      check("auto_restart_cycles", n, 20);
`else
      n = 0;
      cyc(1000);
      check("result_held", state, 3'd6);
`endif
      cyc(5);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
